// File: rtl/rib_arbiter.sv
// rib_arbiter: four-master / single-slave RIB bus arbiter with a per-transaction timeout.
// Build option RIB_RR_EN: round-robin among m0..m2 (m3 keeps absolute priority).
module rib_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            m_req_i,
    input  logic [3:0]            m_we_i,
    input  logic [4*ADDR_W-1:0]   m_addr_i,
    input  logic [4*DATA_W-1:0]   m_wdata_i,
    output logic [3:0]            m_ack_o,
    output logic [DATA_W-1:0]     m_rdata_o,
    output logic                  s_req_o,
    output logic                  s_we_o,
    output logic [ADDR_W-1:0]     s_addr_o,
    output logic [DATA_W-1:0]     s_wdata_o,
    input  logic [DATA_W-1:0]     s_rdata_i,
    input  logic                  s_ack_i,
    output logic                  hold_flag_o,
    output logic                  err_o,
    output logic [ADDR_W-1:0]     err_addr_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t            state, state_next;
    logic [1:0]        grant, grant_next;
    logic [15:0]       cnt, cnt_next;
    logic [3:0]        eligible;
    logic [1:0]        pick;
    logic              timeout_hit;

    logic [ADDR_W-1:0] addr_arr  [4];
    logic [DATA_W-1:0] wdata_arr [4];

    logic              s_req_next;
    logic              s_we_next;
    logic [ADDR_W-1:0] s_addr_next;
    logic [DATA_W-1:0] s_wdata_next;
    logic [3:0]        m_ack_next;
    logic [DATA_W-1:0] m_rdata_next;
    logic              hold_next;
    logic              err_next;
    logic [ADDR_W-1:0] err_addr_next;

`ifdef RIB_RR_EN
    logic [1:0]        last, last_next;
    logic [1:0]        cand;
    logic              found;
`endif

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            addr_arr[i]  = m_addr_i[i*ADDR_W +: ADDR_W];
            wdata_arr[i] = m_wdata_i[i*DATA_W +: DATA_W];
        end
    end

    // The master acked this cycle still shows its request; mask it off.
    assign eligible    = m_req_i & ~m_ack_o;
    assign timeout_hit = (state == BUSY) && !s_ack_i && (cnt == CNT_LAST);

`ifdef RIB_RR_EN
    always_comb begin
        pick  = 2'd3;
        cand  = 2'd0;
        found = 1'b0;
        if (!eligible[3]) begin
            pick = 2'd0;
            for (int unsigned k = 1; k <= 3; k++) begin
                cand = 2'((32'(last) + k) % 3);
                if (eligible[cand] && !found) begin
                    pick  = cand;
                    found = 1'b1;
                end
            end
        end
    end
`else
    always_comb begin
        if (eligible[3])      pick = 2'd3;
        else if (eligible[0]) pick = 2'd0;
        else if (eligible[1]) pick = 2'd1;
        else                  pick = 2'd2;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            grant       <= '0;
            cnt         <= '0;
            s_req_o     <= 1'b0;
            s_we_o      <= 1'b0;
            s_addr_o    <= '0;
            s_wdata_o   <= '0;
            m_ack_o     <= '0;
            m_rdata_o   <= '0;
            hold_flag_o <= 1'b0;
            err_o       <= 1'b0;
            err_addr_o  <= '0;
`ifdef RIB_RR_EN
            last        <= 2'd2;
`endif
        end else begin
            state       <= state_next;
            grant       <= grant_next;
            cnt         <= cnt_next;
            s_req_o     <= s_req_next;
            s_we_o      <= s_we_next;
            s_addr_o    <= s_addr_next;
            s_wdata_o   <= s_wdata_next;
            m_ack_o     <= m_ack_next;
            m_rdata_o   <= m_rdata_next;
            hold_flag_o <= hold_next;
            err_o       <= err_next;
            err_addr_o  <= err_addr_next;
`ifdef RIB_RR_EN
            last        <= last_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|eligible) state_next = BUSY;
            BUSY:    if (s_ack_i || timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        grant_next    = grant;
        cnt_next      = cnt;
        s_req_next    = s_req_o;
        s_we_next     = s_we_o;
        s_addr_next   = s_addr_o;
        s_wdata_next  = s_wdata_o;
        m_ack_next    = '0;
        m_rdata_next  = m_rdata_o;
        hold_next     = hold_flag_o;
        err_next      = 1'b0;
        err_addr_next = err_addr_o;
`ifdef RIB_RR_EN
        last_next     = last;
`endif
        case (state)
            IDLE: begin
                if (|eligible) begin
                    grant_next   = pick;
                    cnt_next     = '0;
                    s_req_next   = 1'b1;
                    s_we_next    = m_we_i[pick];
                    s_addr_next  = addr_arr[pick];
                    s_wdata_next = wdata_arr[pick];
                    hold_next    = pick[1];
`ifdef RIB_RR_EN
                    if (pick != 2'd3) last_next = pick;
`endif
                end
            end
            BUSY: begin
                if (s_ack_i) begin
                    m_ack_next[grant] = 1'b1;
                    m_rdata_next      = s_rdata_i;
                    s_req_next        = 1'b0;
                    hold_next         = 1'b0;
                end else if (timeout_hit) begin
                    m_ack_next[grant] = 1'b1;
                    m_rdata_next      = '0;
                    s_req_next        = 1'b0;
                    hold_next         = 1'b0;
                    err_next          = 1'b1;
                    err_addr_next     = s_addr_o;
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            default: ;
        endcase
    end

endmodule
